gen_layer_sequencer: RTL
========================

GEN_LAYER_SEQUENCER -- requirements
Module: gen_layer_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40000, max cycles allowed per stage before watchdog error.
REQ-002 SHALL have parameter FRAME_CNT_W, default 16, width of the frame counter.
REQ-003 SHALL have ports `clk`  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port `rst`  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port `start`  input  1  request one full generator pass (L1->L2->L3).
REQ-006 SHALL have port `abort`  input  1  cancel the pass in progress.
REQ-007 SHALL have ports `l1_start`, `l2_start`, `l3_start`  output  1 each  one-cycle start pulses to the layer engines.
REQ-008 SHALL have ports `l1_done`, `l2_done`, `l3_done`  input  1 each  one-cycle completion pulses from the layer engines.
REQ-009 SHALL have ports `cap_l1`, `cap_l2`, `cap_l3`  output  1 each  one-cycle enables to latch that layer's flat output bus into its inter-layer buffer.
REQ-010 SHALL have port `busy`  output  1  high while in any RUN state.
REQ-011 SHALL have port `done`  output  1  one-cycle pulse on pass completion.
REQ-012 SHALL have port `stage`  output  2  0=idle, 1=L1, 2=L2, 3=L3.
REQ-013 SHALL have port `err`  output  1  sticky watchdog error flag.
REQ-014 SHALL have port `frame_count`  output  FRAME_CNT_W  count of completed passes.

Function
REQ-015 SHALL implement FSM states IDLE, L1_RUN, L2_RUN, L3_RUN, FIN, ERR.
REQ-016 In IDLE, `start`=1 at edge N SHALL move to L1_RUN, pulse `l1_start` during cycle N+1 only, and clear `err`.
REQ-017 In Lk_RUN, `lk_done`=1 at edge N SHALL pulse `cap_lk` during cycle N+1; for k<3 it SHALL also enter L(k+1)_RUN and pulse `l(k+1)_start` during cycle N+1.
REQ-018 `l3_done` in L3_RUN SHALL enter FIN, which SHALL last one cycle with `done`=1 and then return to IDLE.
REQ-019 `frame_count` SHALL increment by 1 in the FIN cycle and wrap modulo 2^FRAME_CNT_W.
REQ-020 A `start` seen outside IDLE SHALL be ignored and not queued.
REQ-021 A `done` input from a non-current layer SHALL be ignored, with no capture pulse and no state change.
REQ-022 `abort` in any RUN state SHALL return to IDLE at the next edge with no `done`, no capture pulse and no `frame_count` change; abort in IDLE or FIN SHALL be ignored.
REQ-023 If `abort` and the current `lk_done` are high together, `abort` SHALL win.
REQ-024 `busy` SHALL be 1 exactly in L1_RUN, L2_RUN and L3_RUN.
REQ-025 `stage` SHALL be decoded combinationally from the state; all pulse outputs SHALL be registered.

Reset
REQ-026 `rst` SHALL force IDLE and drive every output to 0, including `frame_count` and `err`; this SHALL apply mid-pass with no pulse emitted afterwards.
REQ-027 `rst` SHALL take priority over `start`, `abort` and all `done` inputs.

Configuration
REQ-028 Macro GEN_SEQ_WATCHDOG_EN SHALL compile the watchdog in or out.
REQ-029 With GEN_SEQ_WATCHDOG_EN defined:
- a per-stage counter SHALL clear on entering each RUN state;
- if TIMEOUT_CYCLES cycles pass with no matching done, the FSM SHALL enter ERR, set `err`=1, and return to IDLE on the next edge;
- `err` SHALL stay 1 until the next accepted `start` or `rst`;
- a done arriving in the same cycle as expiry SHALL win.
REQ-030 Without the macro, no counter SHALL exist, ERR SHALL be unreachable, and `err` SHALL be constant 0.

Structure
REQ-031 Package gen_seq_pkg SHALL hold the FSM state enum, the stage codes (STAGE_IDLE..STAGE_L3) and the default TIMEOUT_CYCLES constant.
REQ-032 The watchdog SHALL be sub-module gen_seq_watchdog (inputs clear/enable, output expired), instantiated only under GEN_SEQ_WATCHDOG_EN.

Verification
REQ-033 Nominal pass: start at cycle 0, stub dones 5 cycles after each start → l1/l2/l3_start and cap pulses in order, then done=1 for exactly one cycle, frame_count=1, stage sequence 1,2,3,0.
REQ-034 Ignored inputs: start pulsed during L2_RUN, and l3_done injected during L1_RUN → no state change, no extra pulses, a single done at the end.
REQ-035 Abort: abort together with l2_done during L2_RUN → IDLE next cycle, no cap_l2, no l3_start, frame_count unchanged.
REQ-036 Reset mid-pass: rst during L3_RUN → all outputs 0 next cycle; a later start gives a clean full pass and frame_count=1.
REQ-037 Watchdog (macro on, TIMEOUT_CYCLES=8): withhold l1_done → err=1 after 8 cycles in L1_RUN, then IDLE; the next start clears err. With the macro off, the same stimulus leaves the block in L1_RUN with err=0.
REQ-038 Wrap: FRAME_CNT_W=2, run 5 passes → frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/gen_seq_pkg.sv
// -----------------------------------------------------------------------------
// gen_seq_pkg
// Shared definitions for the generator layer sequencer:
//   - state_t                : sequencer FSM state encoding
//   - STAGE_IDLE..STAGE_L3   : codes driven on the 'stage' output
//   - DEFAULT_TIMEOUT_CYCLES : default per-stage watchdog limit
//   - stage_of()             : state -> stage code decode
// -----------------------------------------------------------------------------
package gen_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_L1_RUN = 3'd1,
        ST_L2_RUN = 3'd2,
        ST_L3_RUN = 3'd3,
        ST_FIN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [1:0] STAGE_IDLE = 2'd0;
    localparam logic [1:0] STAGE_L1   = 2'd1;
    localparam logic [1:0] STAGE_L2   = 2'd2;
    localparam logic [1:0] STAGE_L3   = 2'd3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 40000;

    // FIN and ERR report idle: only the layer-running states have a stage.
    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] v;
        case (s)
            ST_L1_RUN: v = STAGE_L1;
            ST_L2_RUN: v = STAGE_L2;
            ST_L3_RUN: v = STAGE_L3;
            default:   v = STAGE_IDLE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/gen_seq_watchdog.sv
// -----------------------------------------------------------------------------
// gen_seq_watchdog
// Per-stage cycle counter. Counts cycles while 'enable' is high and raises
// 'expired' during the TIMEOUT_CYCLES-th enabled cycle since the last clear.
// Ports:
//   clk     in  clock (rising edge)
//   rst     in  synchronous active-high reset
//   clear   in  restart the count (asserted on each stage entry)
//   enable  in  count this cycle (a RUN state is active)
//   expired out combinational, high on the final allowed cycle of a stage
// 'expired' depends only on the counter and 'enable', never on 'clear', so the
// parent may derive 'clear' from its next-state logic without a loop.
// -----------------------------------------------------------------------------
module gen_seq_watchdog
    import gen_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter; saturates at LAST so it can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= CNT_W'(0);
        end else if (clear) begin
            r_count <= CNT_W'(0);
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/gen_layer_sequencer.sv
// -----------------------------------------------------------------------------
// gen_layer_sequencer
// Runs one generator pass L1 -> L2 -> L3: issues a start pulse to each layer
// engine, waits for its done pulse, and asks for that layer's output to be
// captured into its inter-layer buffer.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   start, abort             begin a pass (IDLE only) / cancel a running pass
//   l1_start..l3_start  out  one-cycle start pulses to the layer engines
//   l1_done..l3_done    in   one-cycle completion pulses from the engines
//   cap_l1..cap_l3      out  one-cycle capture enables for the layer buffers
//   busy, done          out  a layer is running / pass completed (one cycle)
//   stage               out  0 idle, 1..3 layer in progress
//   err                 out  sticky watchdog error
//   frame_count         out  completed passes, wraps at 2^FRAME_CNT_W
// Build option: define GEN_SEQ_WATCHDOG_EN to include the per-stage watchdog
// (gen_seq_watchdog). Without it ERR is unreachable and err is tied to 0.
// -----------------------------------------------------------------------------
module gen_layer_sequencer
    import gen_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   l1_start,
    output logic                   l2_start,
    output logic                   l3_start,
    input  logic                   l1_done,
    input  logic                   l2_done,
    input  logic                   l3_done,
    output logic                   cap_l1,
    output logic                   cap_l2,
    output logic                   cap_l3,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             stage,
    output logic                   err,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("gen_layer_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    state_t r_state;
    state_t w_next;
    logic   w_run;
    logic   w_expired;
    logic   w_l1_start, w_l2_start, w_l3_start;
    logic   w_cap_l1, w_cap_l2, w_cap_l3;
    logic   w_done;
    logic   r_l1_start, r_l2_start, r_l3_start;
    logic   r_cap_l1, r_cap_l2, r_cap_l3;
    logic   r_done;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    assign w_run = (r_state == ST_L1_RUN) || (r_state == ST_L2_RUN) ||
                   (r_state == ST_L3_RUN);

`ifdef GEN_SEQ_WATCHDOG_EN
    logic w_wd_clear;
    logic r_err;

    // Any state change restarts the count, which covers every RUN-state entry.
    assign w_wd_clear = (w_next != r_state);

    gen_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_wd_clear),
        .enable (w_run),
        .expired(w_expired)
    );

    // Sticky error: set on entering ERR, cleared only by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_next == ST_ERR) begin
            r_err <= 1'b1;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`else
    assign w_expired = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: abort beats the current layer's done, done beats expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_L1_RUN;
                else       w_next = ST_IDLE;
            end
            ST_L1_RUN: begin
                if (abort)          w_next = ST_IDLE;
                else if (l1_done)   w_next = ST_L2_RUN;
                else if (w_expired) w_next = ST_ERR;
                else                w_next = ST_L1_RUN;
            end
            ST_L2_RUN: begin
                if (abort)          w_next = ST_IDLE;
                else if (l2_done)   w_next = ST_L3_RUN;
                else if (w_expired) w_next = ST_ERR;
                else                w_next = ST_L2_RUN;
            end
            ST_L3_RUN: begin
                if (abort)          w_next = ST_IDLE;
                else if (l3_done)   w_next = ST_FIN;
                else if (w_expired) w_next = ST_ERR;
                else                w_next = ST_L3_RUN;
            end
            ST_FIN:  w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Pulse decode for the coming cycle; registered below so every pulse is a flop.
    always_comb begin
        w_l1_start = (r_state == ST_IDLE) && start;
        w_l2_start = (r_state == ST_L1_RUN) && l1_done && !abort;
        w_l3_start = (r_state == ST_L2_RUN) && l2_done && !abort;
        w_cap_l1   = w_l2_start;
        w_cap_l2   = w_l3_start;
        w_cap_l3   = (r_state == ST_L3_RUN) && l3_done && !abort;
        w_done     = w_cap_l3;
    end

    // Registered pulse outputs; done is high exactly during the FIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l1_start <= 1'b0;
            r_l2_start <= 1'b0;
            r_l3_start <= 1'b0;
            r_cap_l1   <= 1'b0;
            r_cap_l2   <= 1'b0;
            r_cap_l3   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_l1_start <= w_l1_start;
            r_l2_start <= w_l2_start;
            r_l3_start <= w_l3_start;
            r_cap_l1   <= w_cap_l1;
            r_cap_l2   <= w_cap_l2;
            r_cap_l3   <= w_cap_l3;
            r_done     <= w_done;
        end
    end

    // Completed-pass counter, advanced at the edge that closes the FIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= FRAME_CNT_W'(0);
        end else if (r_state == ST_FIN) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
        end else begin
            r_frame_count <= r_frame_count;
        end
    end

    assign l1_start    = r_l1_start;
    assign l2_start    = r_l2_start;
    assign l3_start    = r_l3_start;
    assign cap_l1      = r_cap_l1;
    assign cap_l2      = r_cap_l2;
    assign cap_l3      = r_cap_l3;
    assign done        = r_done;
    assign busy        = w_run;
    assign stage       = stage_of(r_state);
    assign frame_count = r_frame_count;

endmodule
